nibble_serial_add_ctrl: RTL and testbench



---
 rtl/nibble_serial_add_ctrl.sv | 132 +++++++++++++
 tb/tb_nibble_serial_add_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_add_ctrl.sv
// Nibble-serial W-bit add/subtract sequencer: one 4-bit adder slice reused over NIBBLES clocks.
// Optional signed overflow output is enabled with `define SIGNED_OVF_EN.
module nibble_serial_add_ctrl #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   sub,
  input  logic [4*NIBBLES-1:0]   op_a,
  input  logic [4*NIBBLES-1:0]   op_b,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   result,
  output logic                   carry_out,
  output logic                   overflow
);

  localparam int unsigned W    = 4 * NIBBLES;
  localparam int unsigned IdxW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NIBBLES - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    acc_q, acc_d;
  logic [W-1:0]    result_q, result_d;
  logic            c_q, c_d;
  logic            carry_q, carry_d;
  logic [IdxW-1:0] idx_q, idx_d;

  logic [3:0]      slice_sum;
  logic            slice_cout;
  logic            load;

  // Shared 4-bit parallel adder slice: low nibbles of the operand shifters plus carry register.
  always_comb begin
    {slice_cout, slice_sum} = {1'b0, a_q[3:0]} + {1'b0, b_q[3:0]} + {4'b0000, c_q};
  end

  // Start is honoured in IDLE and in the DONE cycle (back-to-back), never while running.
  assign load = start && (state_q != StRun);

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    result_d = result_q;
    c_d      = c_q;
    carry_d  = carry_q;
    idx_d    = idx_q;
    unique case (state_q)
      StIdle: ;
      StRun: begin
        a_d   = a_q >> 4;
        b_d   = b_q >> 4;
        c_d   = slice_cout;
        acc_d = {slice_sum, acc_q[W-1:4]};
        idx_d = idx_q + 1'b1;
        if (idx_q == LastIdx) begin
          state_d  = StDone;
          result_d = {slice_sum, acc_q[W-1:4]};
          carry_d  = slice_cout;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (load) begin
      state_d = StRun;
      a_d     = op_a;
      b_d     = sub ? ~op_b : op_b;
      c_d     = sub;
      idx_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
      c_q      <= 1'b0;
      carry_q  <= 1'b0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      c_q      <= c_d;
      carry_q  <= carry_d;
      idx_q    <= idx_d;
    end
  end

`ifdef SIGNED_OVF_EN
  logic ovf_q, ovf_d;

  // On the last nibble the shifter low nibbles hold the operand MSB nibbles.
  always_comb begin
    ovf_d = ovf_q;
    if (state_q == StRun && idx_q == LastIdx) begin
      ovf_d = (a_q[3] == b_q[3]) && (slice_sum[3] != a_q[3]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign overflow = ovf_q;
`else
  assign overflow = 1'b0;
`endif

  assign busy      = (state_q == StRun);
  assign done      = (state_q == StDone);
  assign result    = result_q;
  assign carry_out = carry_q;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Randomised self-checking bench for nibble_serial_add_ctrl against an arithmetic reference.
// Honours SIGNED_OVF_EN in the same way as the design.
module tb_nibble_serial_add_ctrl;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         sub;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         carry_out;
  logic         overflow;

  int total;
  int bad;

  logic [W-1:0] last_res;
  logic         last_c;
  logic         last_o;

  nibble_serial_add_ctrl #(.NIBBLES(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .sub       (sub),
    .op_a      (op_a),
    .op_b      (op_b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain modular arithmetic and two's-complement sign rules.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       output logic [W-1:0] r, output logic c, output logic o);
    int unsigned ua, ub;
    ua = a;
    ub = b;
    if (s) begin
      r = W'(ua - ub);
      c = (ua >= ub);
    end else begin
      r = W'(ua + ub);
      c = ((ua + ub) >= (1 << W));
    end
`ifdef SIGNED_OVF_EN
    if (s) o = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
    else   o = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
`else
    o = 1'b0;
`endif
  endtask

  // Called at a negedge; returns at the negedge just after the done cycle.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       input bit poke_start);
    logic [W-1:0] er;
    logic         ec, eo;
    int           busy_cnt;
    int           guard;
    model(a, b, s, er, ec, eo);
    start = 1'b1;
    op_a  = a;
    op_b  = b;
    sub   = s;
    @(negedge clk);
    start    = 1'b0;
    op_a     = W'($urandom);
    op_b     = W'($urandom);
    sub      = 1'($urandom);
    busy_cnt = 0;
    guard    = 0;
    while (!done && guard < 50) begin
      if (busy) busy_cnt++;
      check("result_held", result, last_res);
      if (poke_start && busy_cnt == 2) begin
        start = 1'b1;
        op_a  = 16'hAAAA;
        op_b  = 16'h1111;
        sub   = 1'b0;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      guard++;
    end
    start = 1'b0;
    check("done_timeout", guard < 50, 1);
    check("busy_cycles", busy_cnt, N);
    check("busy_in_done", busy, 0);
    check("result", result, er);
    check("carry_out", carry_out, ec);
    check("overflow", overflow, eo);
    last_res = er;
    last_c   = ec;
    last_o   = eo;
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("busy_after", busy, 0);
  endtask

  initial begin
    logic [W-1:0] er;
    logic         ec, eo;
    total    = 0;
    bad      = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    sub      = 1'b0;
    op_a     = '0;
    op_b     = '0;
    last_res = '0;
    last_c   = 1'b0;
    last_o   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_carry", carry_out, 0);
    check("rst_ovf", overflow, 0);
    rst_n = 1'b1;
    @(negedge clk);

    do_op(16'h1234, 16'h4321, 1'b0, 0);
    do_op(16'hFFFF, 16'h0001, 1'b0, 0);
    do_op(16'h0005, 16'h0007, 1'b1, 0);
    do_op(16'h0007, 16'h0005, 1'b1, 0);
    do_op(16'h7FFF, 16'h0001, 1'b0, 0);
    do_op(16'h8000, 16'h0001, 1'b1, 0);
    do_op(16'h1000, 16'h0001, 1'b0, 1);
    check("ignored_start", result, 16'h1001);

    // Back-to-back: start during the DONE cycle goes straight back to RUN.
    start = 1'b1;
    op_a  = 16'h0102;
    op_b  = 16'h0304;
    sub   = 1'b0;
    @(negedge clk);
    start = 1'b0;
    begin : b2b
      int guard;
      guard = 0;
      while (!done && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      check("b2b_timeout1", guard < 50, 1);
    end
    check("b2b_first", result, 16'h0406);
    model(16'h2222, 16'h1111, 1'b1, er, ec, eo);
    start = 1'b1;
    op_a  = 16'h2222;
    op_b  = 16'h1111;
    sub   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy_next", busy, 1);
    begin : b2b2
      int guard;
      guard = 0;
      while (!done && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      check("b2b_timeout2", guard < 50, 1);
    end
    check("b2b_second", result, er);
    check("b2b_second_c", carry_out, ec);
    last_res = er;
    @(negedge clk);

    // Reset in the middle of RUN aborts without a done pulse.
    start = 1'b1;
    op_a  = 16'h1111;
    op_b  = 16'h2222;
    sub   = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_result", result, 0);
    check("abort_carry", carry_out, 0);
    check("abort_ovf", overflow, 0);
    @(negedge clk);
    rst_n = 1'b1;
    last_res = '0;
    repeat (N + 2) begin
      @(negedge clk);
      check("abort_no_done", done, 0);
    end

    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom);
      rb = W'($urandom);
      if (i % 8 == 0) rb = ~ra;
      do_op(ra, rb, 1'($urandom), (i % 5 == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL global_timeout: got=stuck expected=finish");
    $fatal(1, "timeout");
  end

endmodule
